lsu_ctrl: RTL and testbench

- Load/store sequencing controller between the core's memory stage and the data-memory bus.
- Accepts one request at a time over a valid/ready handshake. Checks alignment, then drives a variable-latency req/ack memory port with byte-lane masks and replicated store data.
- For loads, extracts the addressed lane and sign/zero-extends it through an internal extend_data instance. Returns a registered response; a cycle-count timeout bounds every access.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/extend_data.sv | 21 ++
 rtl/lsu_ctrl.sv | 152 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencing controller.
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} lsu_state_e;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] EXT_ZERO16 = 2'b00;
   localparam logic [1:0] EXT_ZERO8  = 2'b01;
   localparam logic [1:0] EXT_SIGN16 = 2'b10;
   localparam logic [1:0] EXT_SIGN8  = 2'b11;

   localparam int unsigned CNT_W = 8;

   // Size 11 is never legal; half and word need natural alignment.
   function automatic logic is_legal(logic [1:0] size, logic [1:0] off);
      case (size)
         SZ_BYTE: is_legal = 1'b1;
         SZ_HALF: is_legal = ~off[0];
         SZ_WORD: is_legal = (off == 2'b00);
         default: is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/extend_data.sv
// Zero/sign extension of an 8- or 16-bit value to 32 bits.
module extend_data
   import lsu_pkg::*;
(
   input  logic [15:0] init_data,
   input  logic [1:0]  ext_data_val,
   output logic [31:0] extended_data
);

   always_comb begin
      extended_data = 32'h0;
      case (ext_data_val)
         EXT_ZERO16: extended_data = {16'h0, init_data};
         EXT_ZERO8:  extended_data = {24'h0, init_data[7:0]};
         EXT_SIGN16: extended_data = {{16{init_data[15]}}, init_data};
         EXT_SIGN8:  extended_data = {{24{init_data[7]}}, init_data[7:0]};
         default:    extended_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: alignment check, req/ack bus access with lane masks,
// load extraction/extension, registered one-cycle response and access timeout.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_bmask,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_e       state_q, state_d;
   logic             we_q, uns_q;
   logic [1:0]       size_q, off_q;
   logic [CNT_W-1:0] cnt_q;

   logic        accept, legal, to_hit;
   logic [31:0] wdata_rep;
   logic [3:0]  bmask;
   logic [15:0] lane;
   logic [1:0]  ext_mode;
   logic [31:0] ext_out, load_data;

   assign accept = req_valid & req_ready;
   assign legal  = is_legal(req_size, req_addr[1:0]);
   // An ack in the final counted cycle takes priority over the timeout.
   assign to_hit = (state_q == ISSUE) & ~mem_ack & (cnt_q == TO_LAST);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = legal ? ISSUE : RESP;
         ISSUE:   if (mem_ack || to_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE) & ~rst;
      case (req_size)
         SZ_BYTE: begin
            wdata_rep = {4{req_wdata[7:0]}};
            bmask     = 4'b0001 << req_addr[1:0];
         end
         SZ_HALF: begin
            wdata_rep = {2{req_wdata[15:0]}};
            bmask     = 4'b0011 << {req_addr[1], 1'b0};
         end
         default: begin
            wdata_rep = req_wdata;
            bmask     = 4'b1111;
         end
      endcase
      case (off_q)
         2'd0:    lane = mem_rdata[15:0];
         2'd1:    lane = mem_rdata[23:8];
         2'd2:    lane = mem_rdata[31:16];
         default: lane = {8'h00, mem_rdata[31:24]};
      endcase
      if (size_q == SZ_HALF) ext_mode = uns_q ? EXT_ZERO16 : EXT_SIGN16;
      else                   ext_mode = uns_q ? EXT_ZERO8  : EXT_SIGN8;
      load_data = (size_q == SZ_WORD) ? mem_rdata : ext_out;
   end

   extend_data u_extend_data (
      .init_data     (lane),
      .ext_data_val  (ext_mode),
      .extended_data (ext_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q      <= 1'b0;
         uns_q     <= 1'b0;
         size_q    <= 2'b00;
         off_q     <= 2'b00;
         cnt_q     <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_bmask <= 4'h0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  we_q   <= req_we;
                  uns_q  <= req_unsigned;
                  size_q <= req_size;
                  off_q  <= req_addr[1:0];
                  cnt_q  <= '0;
                  if (legal) begin
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= wdata_rep;
                     mem_bmask <= bmask;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               cnt_q <= cnt_q + 1'b1;
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= we_q ? 32'h0 : load_data;
               end else if (to_hit) begin
                  mem_req   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized transactions
// checked against an arithmetic reference model.
module tb_lsu_ctrl;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_bmask;

   int n_cmp = 0;
   int n_err = 0;

   lsu_ctrl #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_bmask    (mem_bmask),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_legal(input int unsigned size, input logic [31:0] addr);
      if (size == 3) return 1'b0;
      if (size == 1 && addr % 2 != 0) return 1'b0;
      if (size == 2 && addr % 4 != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_mask(input int unsigned size, input logic [31:0] addr);
      if (size == 0) return 32'(1 << (addr % 4));
      if (size == 1) return 32'(3 << (addr % 4));
      return 32'd15;
   endfunction

   function automatic logic [31:0] m_wdata(input int unsigned size, input logic [31:0] wdata);
      if (size == 0) return (wdata % 256) * 32'h0101_0101;
      if (size == 1) return (wdata % 65536) * 32'h0001_0001;
      return wdata;
   endfunction

   function automatic logic [31:0] m_load(input int unsigned size, input bit uns,
                                          input logic [31:0] addr, input logic [31:0] rdata);
      logic [31:0] v;
      if (size == 2) return rdata;
      v = rdata >> (8 * (addr % 4));
      if (size == 0) begin
         v = v % 256;
         if (!uns && v >= 128) v = v - 256;
      end else begin
         v = v % 65536;
         if (!uns && v >= 32768) v = v - 65536;
      end
      return v;
   endfunction

   task automatic run_txn(input bit we, input int unsigned size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int unsigned delay);
      bit done, timed_out;
      logic [31:0] exp_rd;
      done = 0;
      timed_out = 0;
      @(negedge clk);
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_we = we;
      req_size = size[1:0];
      req_unsigned = uns;
      req_addr = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (!m_legal(size, addr)) begin
         @(negedge clk);
         check("err_rsp_valid", rsp_valid, 1);
         check("err_rsp_err", rsp_err, 1);
         check("err_rsp_rdata", rsp_rdata, 0);
         check("err_no_mem_req", mem_req, 0);
      end else begin
         for (int k = 0; k < int'(TO) && !done; k++) begin
            @(negedge clk);
            check("mem_req", mem_req, 1);
            check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            check("mem_we", mem_we, we);
            check("mem_wdata", mem_wdata, we ? m_wdata(size, wdata) : mem_wdata);
            check("mem_bmask", mem_bmask, m_mask(size, addr));
            check("rsp_quiet_issue", rsp_valid, 0);
            if (k == int'(delay)) begin
               mem_ack = 1'b1;
               mem_rdata = rdata;
               done = 1;
            end else if (k == int'(TO) - 1) begin
               timed_out = 1;
            end
            @(posedge clk);
            #1 mem_ack = 1'b0;
            mem_rdata = $urandom;
         end
         @(negedge clk);
         exp_rd = (timed_out || we) ? 32'h0 : m_load(size, uns, addr, rdata);
         check("mem_req_dropped", mem_req, 0);
         check("rsp_valid", rsp_valid, 1);
         check("rsp_err", rsp_err, timed_out);
         check("rsp_rdata", rsp_rdata, exp_rd);
         if (timed_out) begin
            mem_ack = 1'b1;
            mem_rdata = $urandom;
         end
      end
      @(posedge clk);
      #1 mem_ack = 1'b0;
      @(negedge clk);
      check("rsp_one_cycle", rsp_valid, 0);
      check("mem_req_idle", mem_req, 0);
      check("req_ready_back", req_ready, 1);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_size = 2'b00;
      req_unsigned = 1'b0;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_bmask", mem_bmask, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      rst = 1'b0;

      run_txn(0, 0, 0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 2);
      run_txn(0, 1, 1, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0);
      run_txn(1, 0, 0, 32'h0000_0001, 32'h0000_00A5, 32'h0, 3);
      run_txn(0, 2, 0, 32'h0000_0006, 32'h0, 32'h0, 0);
      run_txn(0, 2, 0, 32'h0000_0040, 32'h0, 32'h1234_5678, 10);
      run_txn(0, 2, 0, 32'h0000_0044, 32'h0, 32'hCAFE_F00D, TO - 1);

      // Reset in the middle of an access.
      @(negedge clk);
      req_valid = 1'b1;
      req_we = 1'b0;
      req_size = 2'b10;
      req_addr = 32'h0000_0100;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("mid_mem_req", mem_req, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_mem_req", mem_req, 0);
      check("mid_rst_ready", req_ready, 0);
      check("mid_rst_rsp", rsp_valid, 0);
      rst = 1'b0;
      mem_ack = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 mem_ack = 1'b0;
      @(negedge clk);
      check("post_rst_ready", req_ready, 1);
      check("post_rst_rsp", rsp_valid, 0);
      check("post_rst_mem_req", mem_req, 0);
      @(negedge clk);
      check("post_rst_rsp2", rsp_valid, 0);

      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = {$urandom_range(0, 16'hFFFF), 16'h0} | 32'($urandom_range(0, 255));
         run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 a, $urandom, $urandom, $urandom_range(0, TO + 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
